// File: rtl/siphash_sequencer.sv
// siphash_sequencer: drives one complete SipHash message through the siphash
// core command port (we/cmd/busy). It reloads the key at the start of every
// message, streams 64-bit words, appends the length/padding word, finalizes,
// and returns the core result as a one-cycle hash_valid pulse.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   key_we, key            key load (idle only); key[63:0]=k0, key[127:64]=k1
//   start                  begin a message (idle and key loaded)
//   msg_data/valid/ready   64-bit little-endian message word stream
//   msg_last, msg_bytes    final word marker and its valid byte count (0..8)
//   busy                   message in progress
//   hash_valid, hash       one-cycle result pulse, hash held until the next one
//   core_we, core_cmd      command strobe and {opcode[3:0], data[63:0]}
//   core_busy, core_result core status and result
module siphash_sequencer #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned FIN_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_we,
  input  logic [127:0] key,
  input  logic         start,
  input  logic [63:0]  msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  input  logic [3:0]   msg_bytes,
  output logic         msg_ready,
  output logic         busy,
  output logic         hash_valid,
  output logic [63:0]  hash,
  output logic         core_we,
  output logic [67:0]  core_cmd,
  input  logic         core_busy,
  input  logic [63:0]  core_result
);

  localparam int unsigned CNT_W     = (FIN_WAIT > 1) ? $clog2(FIN_WAIT) : 1;
  localparam int unsigned WAIT_LAST = (FIN_WAIT > 0) ? FIN_WAIT - 1 : 0;

  localparam logic [3:0] OP_KEY_LO = 4'h0;
  localparam logic [3:0] OP_KEY_HI = 4'h1;
  localparam logic [3:0] OP_CMP    = 4'h2;
  localparam logic [3:0] OP_FIN    = 4'h3;

  typedef enum logic [3:0] {
    S_IDLE, S_KEY0, S_KEY1, S_MSG, S_CMP, S_PAD, S_FIN, S_CHK, S_FWAIT, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_d;
  logic               r_chk_first, w_chk_first_d;
  logic [63:0]        r_k0, w_k0_d;
  logic [63:0]        r_k1, w_k1_d;
  logic               r_key_loaded, w_key_loaded_d;
  logic [LEN_W-1:0]   r_len, w_len_d;
  logic [63:0]        r_word, w_word_d;
  logic [63:0]        r_pad, w_pad_d;
  logic               r_pad_pending, w_pad_pending_d;
  logic [CNT_W-1:0]   r_wait_cnt, w_wait_cnt_d;
  logic               r_msg_ready, w_msg_ready_d;
  logic               r_busy, w_busy_d;
  logic               r_hash_valid, w_hash_valid_d;
  logic [63:0]        r_hash, w_hash_d;
  logic               r_core_we, w_core_we_d;
  logic [67:0]        r_core_cmd, w_core_cmd_d;

  // Message word datapath: effective byte count, new length, padding words.
  logic               w_accept;
  logic [3:0]         w_nbytes;
  logic [LEN_W-1:0]   w_len_new;
  logic [55:0]        w_mask;
  logic [63:0]        w_pad_short;
  logic [63:0]        w_pad_full;

  assign w_accept    = (r_state == S_MSG) && r_msg_ready && msg_valid;
  assign w_nbytes    = !msg_last ? 4'd8 : ((msg_bytes > 4'd8) ? 4'd8 : msg_bytes);
  assign w_len_new   = r_len + LEN_W'(w_nbytes);
  // Low-byte mask; only used for 0..7 valid bytes, so the top byte is never needed.
  assign w_mask      = 56'((64'h1 << {w_nbytes[2:0], 3'b000}) - 64'h1);
  assign w_pad_short = {8'(w_len_new), msg_data[55:0] & w_mask};
  assign w_pad_full  = {8'(w_len_new), 56'h0};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; command states advance only when the core is idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !key_we && r_key_loaded) w_state_nxt = S_KEY0;
      S_KEY0, S_KEY1, S_CMP, S_PAD, S_FIN:
               if (!core_busy) w_state_nxt = S_CHK;
      S_MSG:   if (w_accept) w_state_nxt = (msg_last && (w_nbytes < 4'd8)) ? S_PAD : S_CMP;
      S_CHK:   if (!r_chk_first && !core_busy) w_state_nxt = r_ret;
      S_FWAIT: if (r_wait_cnt == CNT_W'(WAIT_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; every issue sets the CHK return target.
  always_comb begin
    w_ret_d         = r_ret;
    w_chk_first_d   = 1'b0;
    w_k0_d          = r_k0;
    w_k1_d          = r_k1;
    w_key_loaded_d  = r_key_loaded;
    w_len_d         = r_len;
    w_word_d        = r_word;
    w_pad_d         = r_pad;
    w_pad_pending_d = r_pad_pending;
    w_wait_cnt_d    = r_wait_cnt;
    w_hash_d        = r_hash;
    w_hash_valid_d  = 1'b0;
    w_core_we_d     = 1'b0;
    w_core_cmd_d    = r_core_cmd;
    w_msg_ready_d   = (w_state_nxt == S_MSG);
    w_busy_d        = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (key_we) begin
          w_k0_d         = key[63:0];
          w_k1_d         = key[127:64];
          w_key_loaded_d = 1'b1;
        end else if (start && r_key_loaded) begin
          w_len_d         = '0;
          w_pad_pending_d = 1'b0;
        end
      end
      S_KEY0: if (!core_busy) begin
        w_core_we_d   = 1'b1;
        w_core_cmd_d  = {OP_KEY_LO, r_k0};
        w_ret_d       = S_KEY1;
        w_chk_first_d = 1'b1;
      end
      S_KEY1: if (!core_busy) begin
        w_core_we_d   = 1'b1;
        w_core_cmd_d  = {OP_KEY_HI, r_k1};
        w_ret_d       = S_MSG;
        w_chk_first_d = 1'b1;
      end
      S_MSG: if (w_accept) begin
        w_len_d = w_len_new;
        if (msg_last && (w_nbytes < 4'd8)) begin
          w_pad_d = w_pad_short;
        end else begin
          w_word_d = msg_data;
          if (msg_last) begin
            w_pad_pending_d = 1'b1;
            w_pad_d         = w_pad_full;
          end
        end
      end
      S_CMP: if (!core_busy) begin
        w_core_we_d   = 1'b1;
        w_core_cmd_d  = {OP_CMP, r_word};
        w_ret_d       = r_pad_pending ? S_PAD : S_MSG;
        w_chk_first_d = 1'b1;
      end
      S_PAD: if (!core_busy) begin
        w_core_we_d   = 1'b1;
        w_core_cmd_d  = {OP_CMP, r_pad};
        w_ret_d       = S_FIN;
        w_chk_first_d = 1'b1;
      end
      S_FIN: if (!core_busy) begin
        w_core_we_d   = 1'b1;
        w_core_cmd_d  = {OP_FIN, 64'h0};
        w_ret_d       = S_FWAIT;
        w_chk_first_d = 1'b1;
        w_wait_cnt_d  = '0;
      end
      S_FWAIT: w_wait_cnt_d = r_wait_cnt + CNT_W'(1);
      S_DONE: begin
        w_hash_d       = core_result;
        w_hash_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret         <= S_IDLE;
      r_chk_first   <= 1'b0;
      r_k0          <= '0;
      r_k1          <= '0;
      r_key_loaded  <= 1'b0;
      r_len         <= '0;
      r_word        <= '0;
      r_pad         <= '0;
      r_pad_pending <= 1'b0;
      r_wait_cnt    <= '0;
      r_msg_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_hash_valid  <= 1'b0;
      r_hash        <= '0;
      r_core_we     <= 1'b0;
      r_core_cmd    <= '0;
    end else begin
      r_ret         <= w_ret_d;
      r_chk_first   <= w_chk_first_d;
      r_k0          <= w_k0_d;
      r_k1          <= w_k1_d;
      r_key_loaded  <= w_key_loaded_d;
      r_len         <= w_len_d;
      r_word        <= w_word_d;
      r_pad         <= w_pad_d;
      r_pad_pending <= w_pad_pending_d;
      r_wait_cnt    <= w_wait_cnt_d;
      r_msg_ready   <= w_msg_ready_d;
      r_busy        <= w_busy_d;
      r_hash_valid  <= w_hash_valid_d;
      r_hash        <= w_hash_d;
      r_core_we     <= w_core_we_d;
      r_core_cmd    <= w_core_cmd_d;
    end
  end

  assign msg_ready  = r_msg_ready;
  assign busy       = r_busy;
  assign hash_valid = r_hash_valid;
  assign hash       = r_hash;
  assign core_we    = r_core_we;
  assign core_cmd   = r_core_cmd;

endmodule

// File: doc/siphash_sequencer.md
Name: siphash_sequencer

Overview:
Sequences one complete SipHash message through the `siphash` core's `we`/`cmd`/`busy` command port.
- Holds the 128-bit key and reloads it at the start of every message.
- Accepts the message as a valid/ready stream of 64-bit little-endian words.
- Counts message length, builds the final length/padding word, issues compress commands and then finalize.
- Captures the core result and presents it as a one-cycle `hash_valid` pulse.

Sits between the host/bus adapter and the `siphash` core.

Parameters:
LEN_W, 8, width of the internal byte-length counter; only the low 8 bits enter the padding word (SipHash len mod 256).
FIN_WAIT, 4, cycles to wait after the finalize command before sampling `core_result`, in addition to waiting for `core_busy` low.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
key_we  input  1  load key; accepted only when `busy`=0
key  input  128  key; `key[63:0]`=k0, `key[127:64]`=k1
start  input  1  begin a message; accepted only when `busy`=0 and a key has been loaded
msg_data  input  64  message word, byte 0 in bits [7:0]
msg_valid  input  1  `msg_data` valid
msg_last  input  1  qualifies the final word of the message
msg_bytes  input  4  valid bytes in the last word, 0..8; ignored when `msg_last`=0 (word is full, 8 bytes)
msg_ready  output  1  word accepted when `msg_valid` & `msg_ready`
busy  output  1  message in progress
hash_valid  output  1  one-cycle pulse, `hash` valid
hash  output  64  result, held until the next `hash_valid`
core_we  output  1  command strobe to core
core_cmd  output  68  {opcode[3:0], data[63:0]}
core_busy  input  1  core busy
core_result  input  64  core result

Behaviour:
- Reset (async, `rst_n`=0) clears everything to 0:
  - `busy`, `msg_ready`, `hash_valid`, `hash`, `core_we`, `core_cmd`
  - length counter, key-loaded flag, state = IDLE
  - Key registers are also cleared.
  - Reset asserted mid-message aborts it; no command is completed. After reset a new `key_we` is required before `start`.
- Opcodes driven on `core_cmd[67:64]`:
  - 0000 key low (data=k0)
  - 0001 key high (data=k1)
  - 0010 compress (data=word)
  - 0011 finalize (data=0)
- `core_we` is a single-cycle pulse and is driven only when `core_busy`=0. `core_cmd` holds its value in the pulse cycle.
- Every command is followed by the CHK state: one cycle ignoring `core_busy`, then wait until `core_busy`=0.
- States:
  - IDLE:
    - `key_we` latches `key` and sets key-loaded.
    - `start` with key-loaded -> KEY0, `busy`=1, length counter cleared.
    - `start` without a loaded key is ignored.
    - `key_we` and `start` in the same cycle: the key is latched and `start` is ignored.
  - KEY0: issue 0000 -> CHK -> KEY1.
  - KEY1: issue 0001 -> CHK -> MSG.
  - MSG: `msg_ready`=1. On acceptance:
    - `len += 8` for a non-last word, or `len += msg_bytes` for a last word.
    - Non-last word: capture it -> CMP.
    - Last word with `msg_bytes`=8: capture it, set pad_pending -> CMP.
    - Last word with `msg_bytes` 0..7: form pad = {len_new[7:0], zero bytes [6:msg_bytes], data bytes [msg_bytes-1:0]} -> PAD.
    - `msg_bytes` > 8 is treated as 8.
  - CMP: issue 0010 with the captured word -> CHK.
    - Then go to PAD if pad_pending, or MSG if no last word has been seen.
  - PAD: issue 0010 with the pad word -> CHK -> FIN.
    - When reached via pad_pending, the pad word is {len[7:0], 56'h0}.
  - FIN: issue 0011 -> CHK -> FWAIT.
  - FWAIT: count FIN_WAIT cycles -> DONE.
  - DONE: `hash <= core_result`, `hash_valid`=1 for one cycle, `busy`=0 -> IDLE.
- Length wrap: the counter wraps modulo 2^LEN_W. Only bits [7:0] are used.
- `msg_ready` is 0 outside MSG. No word is accepted while a command is outstanding.
- `start` and `key_we` are ignored while `busy`=1. The key is stable for the whole message.
- An empty message (first word has `msg_last`=1, `msg_bytes`=0) produces exactly one compress with data 64'h0.
- Command count per message:
  - 2 key commands
  - one compress per accepted word with 8 valid bytes
  - one padding compress
  - one finalize

Test Plan:
- Key 0x0f0e..00 (k0=64'h0706050403020100, k1=64'h0f0e0d0c0b0a0908), empty message -> cmd sequence (0000,k0),(0001,k1),(0010,64'h0),(0011,0); `hash_valid` one pulse, `hash` = model `core_result`.
- 3-byte message last word 64'h0000000000020100, `msg_bytes`=3 -> single compress 64'h0300000000020100, then finalize.
- 8-byte message 64'h0706050403020100 with `msg_last`, `msg_bytes`=8 -> compress 64'h0706050403020100, then compress 64'h0800000000000000.
- 34 full words then last with `msg_bytes`=1 (len 273) -> padding word top byte 8'h11; core model holds `core_busy` high 5 cycles per compress and no `core_we` is seen while busy; `msg_valid` toggling randomly loses no words.
- `start` before any `key_we` -> ignored, `busy` stays 0; `key_we` with new key during a message -> ignored, next message uses the old key until reloaded in IDLE.
- Assert `rst_n`=0 asynchronously mid-CMP -> all outputs 0 immediately; after release, `start` ignored until `key_we`.
